// File: rtl/minesweeper_core.sv
// Buscaminas game engine: LFSR mine placement, cursor, reveal/flag and win/lose FSM.
// Board maps are exported flat, indexed y*COLS+x.
module minesweeper_core #(
    parameter int          ROWS = 8,
    parameter int          COLS = 8,
    parameter int          BW   = 7,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter bit          WRAP = 1'b0,
    localparam int         N    = ROWS * COLS,
    localparam int         XW   = $clog2(COLS),
    localparam int         YW   = $clog2(ROWS),
    localparam int         IW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [BW-1:0] bomb_count,
    input  logic [3:0]    inputBtn,
    input  logic          act,
    input  logic          mode,
    output logic [XW-1:0] outX,
    output logic [YW-1:0] outY,
    output logic [N-1:0]  mine_map,
    output logic [N-1:0]  revealed_map,
    output logic [N-1:0]  flag_map,
    output logic [BW-1:0] flags_left,
    output logic [3:0]    adj_count,
    output logic [2:0]    game_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLACE = 3'd1,
        PLAY  = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } state_t;

    localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

    state_t        state;
    logic [15:0]   lfsr;
    logic          start_q;
    logic          act_q;
    logic [3:0]    btn_q;
    logic [BW-1:0] target;
    logic [BW-1:0] placed;
    logic [BW-1:0] clamped;

    logic          start_rise;
    logic          act_rise;
    logic [3:0]    btn_rise;
    logic [IW-1:0] cur;
    logic [IW-1:0] cand;
    logic [IW-1:0] nb;
    logic          safe_done;
    logic [XW-1:0] x_dec;
    logic [XW-1:0] x_inc;
    logic [YW-1:0] y_dec;
    logic [YW-1:0] y_inc;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign game_state = state;
    assign start_rise = start & ~start_q;
    assign act_rise   = act & ~act_q;
    assign btn_rise   = inputBtn & ~btn_q;
    assign cur        = IW'(int'(outY) * COLS + int'(outX));
    assign cand       = lfsr[IW-1:0];
    assign safe_done  = (~mine_map & ~revealed_map) == '0;

    assign clamped = (bomb_count == '0)         ? BW'(1) :
                     (bomb_count > BW'(N - 1))  ? BW'(N - 1) :
                     bomb_count;

    assign x_dec = (outX == '0)   ? (WRAP ? XMAX : '0)   : outX - XW'(1);
    assign x_inc = (outX == XMAX) ? (WRAP ? '0   : XMAX) : outX + XW'(1);
    assign y_dec = (outY == '0)   ? (WRAP ? YMAX : '0)   : outY - YW'(1);
    assign y_inc = (outY == YMAX) ? (WRAP ? '0   : YMAX) : outY + YW'(1);

    // Neighbourhood is clipped at the board edges even when the cursor wraps.
    always_comb begin
        adj_count = '0;
        nb        = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if ((dx != 0 || dy != 0) &&
                    int'(outX) + dx >= 0 && int'(outX) + dx < COLS &&
                    int'(outY) + dy >= 0 && int'(outY) + dy < ROWS) begin
                    nb = IW'((int'(outY) + dy) * COLS + int'(outX) + dx);
                    adj_count = adj_count + 4'(mine_map[nb]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lfsr         <= SEED;
            start_q      <= 1'b0;
            act_q        <= 1'b0;
            btn_q        <= '0;
            target       <= '0;
            placed       <= '0;
            outX         <= '0;
            outY         <= '0;
            mine_map     <= '0;
            revealed_map <= '0;
            flag_map     <= '0;
            flags_left   <= '0;
        end else begin
            lfsr    <= lfsr_step(lfsr);
            start_q <= start;
            act_q   <= act;
            btn_q   <= inputBtn;
            case (state)
                IDLE, WON, LOST: begin
                    if (start_rise) begin
                        mine_map     <= '0;
                        revealed_map <= '0;
                        flag_map     <= '0;
                        flags_left   <= '0;
                        target       <= clamped;
                        placed       <= '0;
                        state        <= PLACE;
                    end
                end
                PLACE: begin
                    if (int'(cand) < N && !mine_map[cand]) begin
                        mine_map[cand] <= 1'b1;
                        placed         <= placed + BW'(1);
                        if (placed + BW'(1) == target) begin
                            flags_left <= target;
                            state      <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    // A losing reveal later in this block overrides the win.
                    if (safe_done) state <= WON;
                    if (btn_rise[3])      outY <= y_dec;
                    else if (btn_rise[2]) outY <= y_inc;
                    else if (btn_rise[1]) outX <= x_dec;
                    else if (btn_rise[0]) outX <= x_inc;
                    if (act_rise && !mode) begin
                        if (!flag_map[cur] && !revealed_map[cur]) begin
                            if (mine_map[cur]) begin
                                revealed_map <= revealed_map | mine_map;
                                state        <= LOST;
                            end else begin
                                revealed_map[cur] <= 1'b1;
                            end
                        end
                    end else if (act_rise && !revealed_map[cur]) begin
                        if (flag_map[cur]) begin
                            flag_map[cur] <= 1'b0;
                            flags_left    <= flags_left + BW'(1);
                        end else if (flags_left != '0) begin
                            flag_map[cur] <= 1'b1;
                            flags_left    <= flags_left - BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minesweeper_core.sv
// Directed bench for minesweeper_core on an 8x8 board, saturating and wrapping cursor.
// Mine placement is predicted by an independent LFSR model.
module tb_minesweeper_core;

    localparam logic [3:0] UP    = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        act = 1'b0;
    logic        mode = 1'b0;
    logic [6:0]  bomb_count = '0;
    logic [3:0]  inputBtn = '0;

    logic [2:0]  outX, outY, game_state;
    logic [63:0] mine_map, revealed_map, flag_map;
    logic [6:0]  flags_left;
    logic [3:0]  adj_count;

    logic [2:0]  w_x, w_y, w_state;
    logic [63:0] w_mine, w_rev, w_flag;
    logic [6:0]  w_flags;
    logic [3:0]  w_adj;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr;
    logic [63:0] exp_map;

    minesweeper_core #(.WRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .bomb_count(bomb_count),
        .inputBtn(inputBtn), .act(act), .mode(mode),
        .outX(outX), .outY(outY), .mine_map(mine_map),
        .revealed_map(revealed_map), .flag_map(flag_map),
        .flags_left(flags_left), .adj_count(adj_count), .game_state(game_state)
    );

    minesweeper_core #(.WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .start(start), .bomb_count(bomb_count),
        .inputBtn(inputBtn), .act(act), .mode(mode),
        .outX(w_x), .outY(w_y), .mine_map(w_mine),
        .revealed_map(w_rev), .flag_map(w_flag),
        .flags_left(w_flags), .adj_count(w_adj), .game_state(w_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic btn(input logic [3:0] b);
        inputBtn = b;
        tick(1);
        inputBtn = '0;
        tick(1);
    endtask

    task automatic do_act(input logic m);
        mode = m;
        act  = 1'b1;
        tick(1);
        act  = 1'b0;
        tick(1);
    endtask

    task automatic go_to(input int x, input int y);
        repeat (8) btn(LEFT);
        repeat (8) btn(UP);
        repeat (x) btn(RIGHT);
        repeat (y) btn(DOWN);
    endtask

    task automatic place_model(input logic [15:0] v0, input int tgt,
                               output logic [63:0] map, output int cyc);
        logic [15:0] v;
        int placed;
        v = v0;
        placed = 0;
        map = '0;
        cyc = 0;
        while (placed < tgt && cyc < 20000) begin
            cyc++;
            if (!map[v[5:0]]) begin
                map[v[5:0]] = 1'b1;
                placed++;
            end
            v = lfsr_step(v);
        end
    endtask

    function automatic int adj_model(input logic [63:0] m, input int x, input int y);
        int c;
        c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 &&
                    y + dy >= 0 && y + dy < 8)
                    c += int'(m[(y + dy) * 8 + x + dx]);
        return c;
    endfunction

    task automatic do_start(input logic [6:0] bc, input int tgt);
        int cyc;
        int n;
        bomb_count = bc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_place", 64'(game_state), 64'd1);
        check("start_clear", mine_map | revealed_map | flag_map, 64'd0);
        place_model(m_lfsr, tgt, exp_map, cyc);
        n = 0;
        while (game_state != 3'd2 && n < 20000) begin
            tick(1);
            n++;
        end
        check("place_cycles", 64'(n), 64'(cyc));
        check("mine_map", mine_map, exp_map);
        check("mine_pop", 64'($countones(mine_map)), 64'(tgt));
        check("flags_init", 64'(flags_left), 64'(tgt));
    endtask

    initial begin
        int idx;
        int fx;
        int fy;
        int rem;
        bit done;

        // Reset state, then async reset during placement.
        tick(2);
        check("rst_state", 64'(game_state), 64'd0);
        check("rst_xy", {58'd0, outY, outX}, 64'd0);
        check("rst_maps", mine_map | revealed_map | flag_map, 64'd0);
        check("rst_flags", 64'(flags_left), 64'd0);
        reset = 1'b1;
        bomb_count = 7'd10;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("mid_place", 64'(game_state), 64'd1);
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("async_state", 64'(game_state), 64'd0);
        check("async_maps", mine_map | revealed_map | flag_map, 64'd0);
        check("async_xy", {58'd0, outY, outX}, 64'd0);
        tick(1);
        reset = 1'b1;

        // Game A: single mine, cursor edge behaviour.
        do_start(7'd0, 1);
        btn(LEFT);
        check("sat_left1", 64'(outX), 64'd0);
        check("wrap_left1", 64'(w_x), 64'd7);
        repeat (9) btn(LEFT);
        check("sat_left10", 64'(outX), 64'd0);
        check("wrap_left10", 64'(w_x), 64'd6);
        repeat (10) btn(RIGHT);
        check("sat_right10", 64'(outX), 64'd7);
        check("wrap_right10", 64'(w_x), 64'd0);
        repeat (2) btn(DOWN);
        btn(UP | RIGHT);
        check("prio_xy", {58'd0, outY, outX}, {58'd0, 3'd1, 3'd7});
        check("prio_xy_w", {58'd0, w_y, w_x}, {58'd0, 3'd1, 3'd0});
        repeat (10) btn(DOWN);
        check("sat_down", 64'(outY), 64'd7);
        check("wrap_down", 64'(w_y), 64'd3);
        idx = 0;
        for (int i = 0; i < 64; i++) if (exp_map[i]) idx = i;
        go_to(idx % 8, idx / 8);
        do_act(1'b0);
        check("lostA_state", 64'(game_state), 64'd4);
        check("lostA_rev", revealed_map, exp_map);

        // Game B: clamp to 63 mines, one safe reveal wins.
        do_start(7'd100, 63);
        idx = 0;
        for (int i = 63; i >= 0; i--) if (!exp_map[i]) idx = i;
        go_to(idx % 8, idx / 8);
        check("adjB", 64'(adj_count), 64'(adj_model(exp_map, idx % 8, idx / 8)));
        mode = 1'b0;
        act = 1'b1;
        tick(1);
        act = 1'b0;
        check("wonB_wait", 64'(game_state), 64'd2);
        tick(1);
        check("wonB_state", 64'(game_state), 64'd3);

        // Game C: flag accounting, then reveal a mine.
        do_start(7'd10, 10);
        go_to(0, 0);
        do_act(1'b1);
        btn(RIGHT);
        do_act(1'b1);
        btn(RIGHT);
        do_act(1'b1);
        check("flag3_left", 64'(flags_left), 64'd7);
        check("flag3_map", flag_map, 64'h7);
        do_act(1'b0);
        check("rev_flagged", revealed_map, 64'd0);
        check("rev_flagged_fl", 64'(flags_left), 64'd7);
        do_act(1'b1);
        check("unflag_left", 64'(flags_left), 64'd8);
        check("unflag_map", flag_map, 64'h3);
        for (int x = 2; x < 8; x++) begin
            do_act(1'b1);
            if (x < 7) btn(RIGHT);
        end
        go_to(0, 1);
        do_act(1'b1);
        btn(RIGHT);
        do_act(1'b1);
        check("flag_all_left", 64'(flags_left), 64'd0);
        check("flag_all_map", flag_map, 64'h3FF);
        btn(RIGHT);
        do_act(1'b1);
        check("flag_zero_left", 64'(flags_left), 64'd0);
        check("flag_zero_map", flag_map, 64'h3FF);
        idx = -1;
        for (int i = 63; i >= 10; i--) if (exp_map[i]) idx = i;
        check("mine_found", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
            fx = idx % 8;
            fy = idx / 8;
            go_to(fx, fy);
            do_act(1'b0);
            check("lostC_state", 64'(game_state), 64'd4);
            check("lostC_rev", revealed_map, exp_map);
            btn(LEFT);
            btn(UP);
            do_act(1'b1);
            do_act(1'b0);
            check("frozen_xy", {58'd0, outY, outX}, 64'(fy * 8 + fx));
            check("frozen_rev", revealed_map, exp_map);
            check("frozen_flag", flag_map, 64'h3FF);
            check("frozen_fl", 64'(flags_left), 64'd0);
            check("frozen_state", 64'(game_state), 64'd4);
        end

        // Game D: reveal every safe cell in raster order.
        do_start(7'd10, 10);
        go_to(0, 0);
        rem = 54;
        done = 1'b0;
        for (int y = 0; y < 8 && !done; y++) begin
            for (int x = 0; x < 8 && !done; x++) begin
                check("adj", 64'(adj_count), 64'(adj_model(exp_map, x, y)));
                if (!exp_map[y * 8 + x]) begin
                    mode = 1'b0;
                    act = 1'b1;
                    tick(1);
                    act = 1'b0;
                    rem--;
                    if (rem == 0) check("wonD_wait", 64'(game_state), 64'd2);
                    tick(1);
                    if (rem == 0) begin
                        check("wonD_state", 64'(game_state), 64'd3);
                        check("wonD_rev", revealed_map, ~exp_map);
                        done = 1'b1;
                    end
                end
                if (!done && x < 7) btn(RIGHT);
            end
            if (!done) begin
                btn(DOWN);
                repeat (7) btn(LEFT);
            end
        end
        check("wonD_reached", 64'(done), 64'd1);
        do_start(7'd5, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
